unit_input_tx: RTL

UNIT_INPUT_TX -- requirements
Module: unit_input_tx

---
 rtl/unit_input_tx_pkg.sv | 29 ++
 rtl/unit_input_tx.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/unit_input_tx_pkg.sv
// Shared constants, packet type codes and FSM encoding for the unit input transmitter.
package unit_input_tx_pkg;

  localparam int UNIT_INPUT_WIDTH_DEF = 8;
  localparam int ENTRY_PT_MSB_DEF     = 4;

  localparam logic [2:0] PKT_TYPE_DATA = 3'd0;
  localparam logic [2:0] PKT_TYPE_EP   = 3'd1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_EP_HDR = 3'd1,
    ST_EP_END = 3'd2,
    ST_HDR    = 3'd3,
    ST_DATA   = 3'd4,
    ST_GAP    = 3'd5
  } state_t;

  // Index of the highest set bit; 0 for an input of 0.
  function automatic int msb(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      r = value[i] ? i : r;
    end
    return r;
  endfunction

endpackage

// File: rtl/unit_input_tx.sv
// Serialises 32-bit FIFO words and entry-point requests into narrow header/data/end
// chunk packets for the unit input bus.
module unit_input_tx
  import unit_input_tx_pkg::*;
#(
  parameter int INPUT_WIDTH  = UNIT_INPUT_WIDTH_DEF,
  parameter int RATIO        = 32 / INPUT_WIDTH,
  parameter int ENTRY_PT_MSB = ENTRY_PT_MSB_DEF
) (
  input  logic                    CLK,
  input  logic                    rst,
  input  logic [31:0]             src_data,
  input  logic                    src_last,
  input  logic                    src_empty,
  output logic                    src_rd_en,
  input  logic                    ep_wr_en,
  input  logic [ENTRY_PT_MSB:0]   ep_value,
  output logic                    ep_busy,
  output logic [INPUT_WIDTH-1:0]  out,
  output logic                    out_ctrl,
  output logic                    out_wr_en,
  input  logic                    unit_afull,
  input  logic                    unit_ready
);

  localparam int CW = msb(RATIO - 1) + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(RATIO - 1);

  state_t                  state_q, state_d;
  logic [CW-1:0]           idx_q, idx_d;
  logic [INPUT_WIDTH-1:0]  out_q, out_d;
  logic                    out_ctrl_q, out_ctrl_d;
  logic                    out_wr_en_q, out_wr_en_d;
  logic                    src_rd_en_q, src_rd_en_d;
  logic                    ep_pending_q, ep_pending_d;
  logic [ENTRY_PT_MSB:0]   ep_val_q, ep_val_d;

  logic data_fire_s;
  logic last_chunk_s;

  // The FIFO head is stale while a pop is in flight, so no chunk goes out that cycle.
  assign data_fire_s  = !unit_afull && !src_empty && !src_rd_en_q;
  assign last_chunk_s = (idx_q == LAST_IDX);

  assign out       = out_q;
  assign out_ctrl  = out_ctrl_q;
  assign out_wr_en = out_wr_en_q;
  assign src_rd_en = src_rd_en_q;
  assign ep_busy   = ep_pending_q;

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      out_q        <= '0;
      out_ctrl_q   <= 1'b0;
      out_wr_en_q  <= 1'b0;
      src_rd_en_q  <= 1'b0;
      ep_pending_q <= 1'b0;
      ep_val_q     <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      out_q        <= out_d;
      out_ctrl_q   <= out_ctrl_d;
      out_wr_en_q  <= out_wr_en_d;
      src_rd_en_q  <= src_rd_en_d;
      ep_pending_q <= ep_pending_d;
      ep_val_q     <= ep_val_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (ep_pending_q && unit_ready) begin
          state_d = ST_EP_HDR;
        end else if (!src_empty && unit_ready && !ep_pending_q) begin
          state_d = ST_HDR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EP_HDR: state_d = ST_EP_END;
      ST_EP_END: state_d = ST_GAP;
      ST_HDR:    state_d = ST_DATA;
      ST_DATA: begin
        if (data_fire_s && last_chunk_s && src_last) begin
          state_d = ST_GAP;
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    out_d        = '0;
    out_ctrl_d   = 1'b0;
    out_wr_en_d  = 1'b0;
    src_rd_en_d  = 1'b0;
    idx_d        = idx_q;
    ep_pending_d = ep_pending_q;
    ep_val_d     = ep_val_q;

    if (ep_wr_en && !ep_pending_q) begin
      ep_pending_d = 1'b1;
      ep_val_d     = ep_value;
    end else begin
      ep_val_d     = ep_val_q;
    end

    case (state_q)
      ST_EP_HDR: begin
        out_wr_en_d                 = 1'b1;
        out_ctrl_d                  = 1'b1;
        out_d[2:0]                  = PKT_TYPE_EP;
        out_d[ENTRY_PT_MSB+3:3]     = ep_val_q;
      end
      ST_EP_END: begin
        out_wr_en_d  = 1'b1;
        out_ctrl_d   = 1'b1;
        ep_pending_d = 1'b0;
      end
      ST_HDR: begin
        out_wr_en_d = 1'b1;
        out_ctrl_d  = 1'b1;
        out_d[2:0]  = PKT_TYPE_DATA;
        idx_d       = '0;
      end
      ST_DATA: begin
        if (data_fire_s) begin
          out_wr_en_d = 1'b1;
          out_d       = src_data[int'(idx_q)*INPUT_WIDTH +: INPUT_WIDTH];
          if (last_chunk_s) begin
            idx_d       = '0;
            src_rd_en_d = 1'b1;
            out_ctrl_d  = src_last;
          end else begin
            idx_d       = idx_q + CW'(1);
          end
        end else begin
          idx_d = idx_q;
        end
      end
      default: begin
        idx_d = idx_q;
      end
    endcase
  end

endmodule
